// File: rtl/abc_sequence_scheduler_if.sv
// ---------------------------------------------------------------------------
// abc_sequence_scheduler_if
//   Signal bundle between the requester side (master) and the sequence
//   scheduler (slave).
//
//   Handshake: req[i] is a level request from requester i. It is only looked
//   at while the scheduler is idle or in the closing G cycle. grant_vld is
//   high for the whole A/B/C/G span of a sequence, and grant_id names the
//   owner whenever grant_vld is high. There is no ready path: a granted
//   requester always gets a full sequence unless abort cuts it short.
//
//   Signals:
//     req[NUM_REQ-1:0]  master -> slave  per-requester request level
//     abort             master -> slave  terminate the current sequence
//     grant_vld         slave -> master  sequence in progress
//     grant_id          slave -> master  granted requester index
//     done              slave -> master  pulse in G of a completed sequence
//     a..g              slave -> master  shared protocol signal group
//     dbg_state         slave -> master  scheduler FSM state, debug only
// ---------------------------------------------------------------------------
interface abc_sequence_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req;
  logic               abort;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic               done;
  logic               a;
  logic               b;
  logic               c;
  logic               d;
  logic               e;
  logic               f;
  logic               g;
  logic [2:0]         dbg_state;

  modport master (
    output req, abort,
    input  grant_vld, grant_id, done, a, b, c, d, e, f, g, dbg_state
  );

  modport slave (
    input  req, abort,
    output grant_vld, grant_id, done, a, b, c, d, e, f, g, dbg_state
  );
endinterface

// File: rtl/abc_sequence_scheduler.sv
// ---------------------------------------------------------------------------
// abc_sequence_scheduler
//   Round-robin scheduler sharing one a/b/c/d/e/f/g protocol channel among
//   NUM_REQ requesters. Each grant produces the sequence
//     a ##1 b[*B_LEN] ##1 c[*C_LEN]
//   with d and f raised in the last c cycle and g one cycle after it, so the
//   monitored implications "|-> d", "|-> !e" and "|-> f ##1 g" hold.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    abc_sequence_scheduler_if.slave (req/abort in, grant and
//            protocol signals out, dbg_state out)
//
//   All outputs are registered and Moore: the register for each output is
//   loaded with the value that belongs to the state being entered, so the
//   outputs always line up with r_state.
// ---------------------------------------------------------------------------
module abc_sequence_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int B_LEN   = 2,
  parameter int C_LEN   = 3,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic                     clk,
  input logic                     rst_n,
  abc_sequence_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_C    = 3'd3,
    S_G    = 3'd4
  } state_t;

  // Last counter value of each phase; the counter restarts at 0 on entry.
  localparam logic [3:0] B_LAST = 4'(B_LEN - 1);
  localparam logic [3:0] C_LAST = 4'(C_LEN - 1);
  localparam logic [ID_W-1:0] ID_MAX = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);

  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [3:0]      r_cnt;
  logic            r_grant_vld;
  logic [ID_W-1:0] r_grant_id;
  logic            r_done;
  logic            r_a;
  logic            r_b;
  logic            r_c;
  logic            r_d;
  logic            r_f;
  logic            r_g;

  logic            w_any_req;
  logic            w_found;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_next_ptr;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;
  logic            w_c_next_last;

  assign w_any_req = |bus.req;

  // Round-robin search: scan NUM_REQ slots starting at the pointer, wrapping
  // at NUM_REQ (which need not be a power of two), first requester wins.
  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(off);
      if (w_sum >= NUM_REQ_X) begin
        w_sum = w_sum - NUM_REQ_X;
      end
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_next_ptr = (w_winner == ID_MAX) ? '0 : w_winner + 1'b1;

  // True when the C cycle being entered next is the final one.
  assign w_c_next_last = ((r_cnt + 4'd1) == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_grant_vld <= 1'b0;
      r_grant_id  <= '0;
      r_done      <= 1'b0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_c         <= 1'b0;
      r_d         <= 1'b0;
      r_f         <= 1'b0;
      r_g         <= 1'b0;
    end else begin
      // Protocol pulses are re-asserted explicitly by the state being
      // entered; everything not named below drops.
      r_done <= 1'b0;
      r_a    <= 1'b0;
      r_b    <= 1'b0;
      r_c    <= 1'b0;
      r_d    <= 1'b0;
      r_f    <= 1'b0;
      r_g    <= 1'b0;

      case (r_state)
        // Arbitration points. G re-arbitrates so a pending requester starts
        // its a cycle immediately after the g cycle.
        S_IDLE, S_G: begin
          r_cnt <= '0;
          if (w_any_req) begin
            r_state     <= S_A;
            r_grant_vld <= 1'b1;
            r_grant_id  <= w_winner;
            r_ptr       <= w_next_ptr;
            r_a         <= 1'b1;
          end else begin
            r_state     <= S_IDLE;
            r_grant_vld <= 1'b0;
          end
        end

        S_A: begin
          r_cnt <= '0;
          if (bus.abort) begin
            r_state     <= S_IDLE;
            r_grant_vld <= 1'b0;
          end else begin
            r_state <= S_B;
            r_b     <= 1'b1;
          end
        end

        S_B: begin
          if (bus.abort) begin
            r_state     <= S_IDLE;
            r_grant_vld <= 1'b0;
            r_cnt       <= '0;
          end else if (r_cnt == B_LAST) begin
            r_state <= S_C;
            r_cnt   <= '0;
            r_c     <= 1'b1;
            // A one-cycle C phase is also its own last cycle.
            r_d     <= (C_LEN == 1);
            r_f     <= (C_LEN == 1);
          end else begin
            r_cnt <= r_cnt + 4'd1;
            r_b   <= 1'b1;
          end
        end

        S_C: begin
          if (bus.abort) begin
            // Also covers abort in the last C cycle: d/f were already shown,
            // only the G cycle is dropped.
            r_state     <= S_IDLE;
            r_grant_vld <= 1'b0;
            r_cnt       <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state <= S_G;
            r_cnt   <= '0;
            r_g     <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            r_c   <= 1'b1;
            r_d   <= w_c_next_last;
            r_f   <= w_c_next_last;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_grant_vld <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign bus.grant_vld = r_grant_vld;
  assign bus.grant_id  = r_grant_id;
  assign bus.done      = r_done;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.c         = r_c;
  assign bus.d         = r_d;
  // e is never asserted by this scheduler.
  assign bus.e         = 1'b0;
  assign bus.f         = r_f;
  assign bus.g         = r_g;
  assign bus.dbg_state = r_state;

endmodule

// File: doc/abc_sequence_scheduler.md
Name: abc_sequence_scheduler

Overview:
- Round-robin scheduler that shares one protocol channel (a/b/c/d/e/f/g signal group) among NUM_REQ requesters.
- For each granted requester it drives the canonical sequence `a ##1 b[*B_LEN] ##1 c[*C_LEN]`, with response signals aligned so that these three properties all hold:
  - `|-> d`
  - `|-> !e`
  - `|-> f ##1 g`
- Sits between requester agents and the shared signal group that the protocol assertions monitor.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- B_LEN, 2, consecutive cycles b is held; legal range 1..15.
- C_LEN, 3, consecutive cycles c is held; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request level; bit i = requester i.
- abort  input  1  terminates the current sequence.
- grant_vld  output  1  high while a sequence is in progress (states A, B, C, G).
- grant_id  output  max(1,$clog2(NUM_REQ))  index of the granted requester; valid when grant_vld.
- done  output  1  one-cycle pulse in the G cycle of a sequence that was not aborted.
- a, b, c, d, e, f, g  output  1 each  shared protocol signal group.

Behaviour:
- Reset: outputs and state are cleared asynchronously.
  - All outputs 0; state IDLE; round-robin pointer 0; phase counter 0.
- Reset may assert mid-sequence. All protocol outputs drop in the same cycle; no partial sequence resumes.
- States and outputs (all outputs registered, Moore):
  - IDLE: all protocol outputs 0; grant_vld=0.
  - A: a=1 for exactly 1 cycle.
  - B: b=1 for exactly B_LEN cycles.
  - C: c=1 for exactly C_LEN cycles.
    - In the last C cycle only, d=1 and f=1 (overlapping implication).
    - e=0 in every cycle, in every state.
  - G: g=1 for 1 cycle; done=1 if the sequence was not aborted.
- Transitions:
  - IDLE -> A when any req bit is high. The winner is registered as grant_id.
  - A -> B.
  - B -> C when the counter reaches B_LEN-1.
  - C -> G when the counter reaches C_LEN-1.
  - G -> A when any req bit is high (re-arbitrated in the G cycle; zero-bubble back-to-back); otherwise G -> IDLE.
- Phase counter:
  - 4 bits; cleared on each state entry; increments each cycle in B and C.
  - It never wraps for legal parameters.
- Arbitration: round-robin starting from the pointer.
  - Lowest index at or after the pointer with req=1 wins, wrapping from NUM_REQ-1 to 0.
  - On grant, the pointer becomes (winner+1) mod NUM_REQ.
  - Arbitration happens only in IDLE or G; req changes during A/B/C are ignored.
  - A requester that drops req after grant still gets a full sequence.
- Abort:
  - Sampled in A, B or C: next state is IDLE, all protocol outputs 0 in the following cycle, no done pulse, no G cycle.
  - Abort in IDLE or G is ignored.
  - Abort in the last C cycle still lets that cycle's d/f appear (already registered). The G cycle is suppressed.
  - The pointer is not rolled back on abort.
- Per-sequence output counts: a, b, c and d are never high in the same cycle except c with d/f in the last C cycle.
  - Exactly one a pulse per sequence.
  - b high for exactly B_LEN consecutive cycles.
  - c high for exactly C_LEN consecutive cycles.
- Latency:
  - req rise in IDLE -> a=1 on the next cycle.
  - Full sequence is 1+B_LEN+C_LEN+1 cycles (7 at defaults).
- Simultaneous req bits: resolved by round-robin only; no fixed priority.

Test Plan:
- Defaults; req=4'b0001 held one cycle -> grant_id=0.
  - a high at cycle 1; b at cycles 2-3; c at cycles 4-6; d=f=1 at cycle 6 only; g=done=1 at cycle 7; IDLE at cycle 8.
  - e=0 throughout.
- req=4'b1111 held continuously -> grants 0,1,2,3,0 in order.
  - Each sequence 7 cycles, back to back; every G cycle is followed immediately by a.
- Fairness: after requester 2 is granted, req=4'b0101 -> next grant is 0 (wrap from pointer 3), then 2.
- Abort:
  - Abort during the 2nd c cycle -> c=0, d=0 next cycle; no g, no done; grant_vld=0.
  - Next pending req starts a new sequence from a.
- rst_n low during B -> all outputs 0 immediately.
  - After release with req=4'b0010 -> grant_id=1 (pointer reset to 0, so arbitration starts from index 0 and finds requester 1).
- B_LEN=1, C_LEN=1 -> sequence a, b, c+d+f, g (4 cycles).
  - Bind the three protocol assertions (`|-> d`, `|-> !e`, `|-> f ##1 g`) to the outputs; all pass across 1000 random req/abort cycles.
